// File: rtl/lif_array_scheduler.sv
// lif_array_scheduler: one shared leak-and-integrate datapath stepping NUM_NEURONS
// virtual neurons in index order, emitting each spike as a valid/ready address event.
module lif_array_scheduler #(
  parameter int NUM_NEURONS = 8,
  parameter int W           = 8,
  parameter int THRESHOLD   = 200,
  parameter int LEAK_SHIFT  = 1,
  parameter int REFRAC      = 2,
  localparam int AW         = $clog2(NUM_NEURONS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [W-1:0]  cfg_current,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_state,
  input  logic          step_start,
  output logic          busy,
  output logic          step_done,
  output logic          ev_valid,
  output logic [AW-1:0] ev_addr,
  input  logic          ev_ready
);
  localparam int RW = REFRAC > 0 ? $clog2(REFRAC + 1) : 1;
  localparam logic [W:0] TH = (W+1)'(THRESHOLD);
  localparam logic [RW-1:0] RF = RW'(REFRAC);
  typedef enum logic [1:0] {IDLE, UPDATE, EMIT, DONE} st_e;
  st_e st_q;
  logic [AW-1:0] idx_q, ev_addr_q;
  logic [W-1:0] state_q [NUM_NEURONS];
  logic [W-1:0] current_q [NUM_NEURONS];
  logic [RW-1:0] refrac_q [NUM_NEURONS];
  logic busy_q, done_q, ev_valid_q;
  logic [W:0] sum;
  logic [W-1:0] state_d;
  logic in_refrac, spike, last;
  // Sum is one bit wider so overflow saturates instead of wrapping below threshold.
  always_comb begin
    sum = {1'b0, state_q[idx_q] >> LEAK_SHIFT} + {1'b0, current_q[idx_q]};
    state_d = sum[W] ? '1 : sum[W-1:0];
    in_refrac = refrac_q[idx_q] != '0;
    spike = !in_refrac && ({1'b0, state_d} >= TH);
    last = &idx_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_NEURONS; k++) begin
        state_q[k] <= '0;
        current_q[k] <= '0;
        refrac_q[k] <= '0;
      end
      st_q <= IDLE;
      idx_q <= '0;
      ev_addr_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ev_valid_q <= 1'b0;
    end else begin
      if (cfg_we) current_q[cfg_addr] <= cfg_current;
      done_q <= 1'b0;
      case (st_q)
        IDLE: if (step_start) begin
          st_q <= UPDATE;
          idx_q <= '0;
          busy_q <= 1'b1;
        end
        UPDATE: begin
          if (in_refrac) begin
            state_q[idx_q] <= '0;
            refrac_q[idx_q] <= refrac_q[idx_q] - RW'(1);
          end else if (spike) begin
            state_q[idx_q] <= '0;
            refrac_q[idx_q] <= RF;
          end else state_q[idx_q] <= state_d;
          if (spike) begin
            st_q <= EMIT;
            ev_valid_q <= 1'b1;
            ev_addr_q <= idx_q;
          end else if (last) begin
            st_q <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else idx_q <= idx_q + AW'(1);
        end
        EMIT: if (ev_ready) begin
          ev_valid_q <= 1'b0;
          if (last) begin
            st_q <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            st_q <= UPDATE;
            idx_q <= idx_q + AW'(1);
          end
        end
        DONE: st_q <= IDLE;
      endcase
    end
  end
  assign rd_state = state_q[rd_addr];
  assign busy = busy_q;
  assign step_done = done_q;
  assign ev_valid = ev_valid_q;
  assign ev_addr = ev_addr_q;
endmodule

// File: tb/tb_lif_array_scheduler.sv
// tb_lif_array_scheduler: scenario tasks checked against an arithmetic per-step model
// of the neuron array (state, current, refractory kept as plain int arrays).
module tb_lif_array_scheduler;
  localparam int N = 8, TH = 200, LS = 1, RF = 2;
  logic clk, rst_n, cfg_we, step_start, busy, step_done, ev_valid, ev_ready;
  logic [2:0] cfg_addr, rd_addr, ev_addr;
  logic [7:0] cfg_current, rd_state;
  int tests, fails;
  int m_st[N], m_cur[N], m_ref[N];

  lif_array_scheduler dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_current(cfg_current), .rd_addr(rd_addr), .rd_state(rd_state),
    .step_start(step_start), .busy(busy), .step_done(step_done),
    .ev_valid(ev_valid), .ev_addr(ev_addr), .ev_ready(ev_ready)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin m_st[i] = 0; m_cur[i] = 0; m_ref[i] = 0; end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; cfg_we = 0; step_start = 0; ev_ready = 1;
    @(negedge clk);
    rst_n = 1;
    model_clear();
  endtask

  task automatic wcur(input int a, input int v);
    @(negedge clk);
    cfg_we = 1; cfg_addr = a[2:0]; cfg_current = v[7:0];
    @(negedge clk);
    cfg_we = 0;
    m_cur[a] = v;
  endtask

  task automatic rd(input int a, output logic [7:0] v);
    @(negedge clk);
    rd_addr = a[2:0];
    #1 v = rd_state;
  endtask

  // One timestep: model predicts the events and final states, DUT is driven with
  // optional first-event stall, optional mid-step current write and a busy-time step_start pulse.
  task automatic run_step(input int stall, input int wr_cyc, input int wr_a, input int wr_v, input bit pulse);
    int exp_q[$];
    int c, st, nev;
    bit done;
    logic [7:0] v;
    for (int i = 0; i < N; i++) begin
      if (m_ref[i] > 0) begin
        m_st[i] = 0; m_ref[i]--;
      end else begin
        int nx;
        nx = (m_st[i] >> LS) + m_cur[i];
        if (nx > 255) nx = 255;
        if (nx >= TH) begin m_st[i] = 0; m_ref[i] = RF; exp_q.push_back(i); end
        else m_st[i] = nx;
      end
    end
    nev = exp_q.size();
    @(negedge clk);
    step_start = 1; ev_ready = 1;
    c = 0; st = stall; done = 0;
    while (!done && c < 300) begin
      @(negedge clk);
      c++;
      step_start = pulse && (c == 2);
      cfg_we = 0;
      if (wr_cyc == c) begin cfg_we = 1; cfg_addr = wr_a[2:0]; cfg_current = wr_v[7:0]; end
      if (step_done) done = 1;
      else begin
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL busy_high cyc=%0d got=%b want=1", c, busy); end
        if (ev_valid) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++; $display("FAIL unexpected_event addr=%0d want=none", ev_addr);
          end else if (ev_addr !== exp_q[0][2:0]) begin
            fails++; $display("FAIL ev_addr got=%0d want=%0d", ev_addr, exp_q[0]);
          end
          ev_ready = (st == 0);
          if (st > 0) st--;
          if (ev_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        end else ev_ready = 1;
      end
    end
    cfg_we = 0; step_start = 0; ev_ready = 1;
    if (wr_cyc > 0) m_cur[wr_a] = wr_v;
    tests++;
    if (!done) begin fails++; $display("FAIL step_timeout got=no step_done want=step_done"); end
    tests++;
    if (c != N + 1 + nev + (nev > 0 ? stall : 0)) begin
      fails++; $display("FAIL latency got=%0d want=%0d", c, N + 1 + nev + (nev > 0 ? stall : 0));
    end
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL missing_events got=%0d want=0 left", exp_q.size()); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL busy_at_done got=%b want=0", busy); end
    @(negedge clk);
    tests++;
    if (step_done !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL done_pulse got=%b/%b want=0/0", step_done, busy);
    end
    for (int i = 0; i < N; i++) begin
      rd(i, v);
      tests++;
      if (v !== m_st[i][7:0]) begin fails++; $display("FAIL state[%0d] got=%0d want=%0d", i, v, m_st[i]); end
    end
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rst_n = 0; cfg_we = 0; cfg_addr = 0; cfg_current = 0; rd_addr = 0; step_start = 0; ev_ready = 1;
    #12 rst_n = 1;
    model_clear();
    @(negedge clk);
    tests++;
    if ({busy, step_done, ev_valid, ev_addr} !== 6'b0) begin
      fails++; $display("FAIL reset_outputs got=%b want=000000", {busy, step_done, ev_valid, ev_addr});
    end
    for (int i = 0; i < N; i++) begin
      rd(i, v);
      tests++;
      if (v !== 8'd0) begin fails++; $display("FAIL reset_state[%0d] got=%0d want=0", i, v); end
    end
  endtask

  task automatic test_subthreshold();
    int exp0[10] = '{100, 150, 175, 187, 193, 196, 198, 199, 199, 199};
    logic [7:0] v;
    do_reset();
    wcur(0, 100);
    for (int s = 0; s < 10; s++) begin
      run_step(0, 0, 0, 0, 0);
      rd(0, v);
      tests++;
      if (v !== exp0[s][7:0]) begin fails++; $display("FAIL subthr_step%0d got=%0d want=%0d", s + 1, v, exp0[s]); end
    end
  endtask

  task automatic test_refractory();
    int exp3[6] = '{120, 180, 0, 0, 0, 120};
    logic [7:0] v;
    do_reset();
    wcur(3, 120);
    for (int s = 0; s < 6; s++) begin
      run_step(0, 0, 0, 0, 0);
      rd(3, v);
      tests++;
      if (v !== exp3[s][7:0]) begin fails++; $display("FAIL refrac_step%0d got=%0d want=%0d", s + 1, v, exp3[s]); end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    wcur(5, 180);
    run_step(0, 0, 0, 0, 0);
    run_step(0, 0, 0, 0, 0);
  endtask

  task automatic test_backpressure();
    do_reset();
    wcur(1, 255);
    wcur(6, 255);
    run_step(5, 0, 0, 0, 0);
  endtask

  task automatic test_concurrent();
    logic [7:0] v;
    do_reset();
    wcur(4, 10);
    run_step(0, 5, 4, 50, 1);
    rd(4, v);
    tests++;
    if (v !== 8'd10) begin fails++; $display("FAIL cfg_same_idx_old got=%0d want=10", v); end
    run_step(0, 0, 0, 0, 0);
    rd(4, v);
    tests++;
    if (v !== 8'd55) begin fails++; $display("FAIL cfg_same_idx_new got=%0d want=55", v); end
  endtask

  task automatic test_reset_mid_step();
    bit seen;
    do_reset();
    wcur(0, 50);
    wcur(2, 255);
    @(negedge clk);
    step_start = 1; ev_ready = 0; seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      step_start = 0;
      seen = ev_valid;
    end
    tests++;
    if (!seen || ev_addr !== 3'd2) begin fails++; $display("FAIL midreset_event got=%b/%0d want=1/2", seen, ev_addr); end
    rst_n = 0;
    rd_addr = 0;
    #1;
    tests++;
    if (ev_valid !== 1'b0 || busy !== 1'b0 || rd_state !== 8'd0) begin
      fails++; $display("FAIL midreset_clear got=%b/%b/%0d want=0/0/0", ev_valid, busy, rd_state);
    end
    @(negedge clk);
    rst_n = 1; ev_ready = 1;
    model_clear();
    run_step(0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < N; i++) wcur(i, $urandom_range(0, 255));
    for (int s = 0; s < 6; s++) run_step($urandom_range(0, 3), 0, 0, 0, 0);
  endtask

  initial begin
    tests = 0; fails = 0;
    test_reset();
    test_subthreshold();
    test_refractory();
    test_saturation();
    test_backpressure();
    test_concurrent();
    test_reset_mid_step();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
